// File: rtl/axi_slv_pkg.sv
// Shared encodings for the AXI memory slave: burst types, response codes and FSM states.
package axi_slv_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // Only power-of-two burst lengths of 2, 4, 8 or 16 beats may wrap.
  function automatic logic len_wrappable(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat address for one AXI burst step; only the in-memory address bits move,
// upper bits pass through untouched.
module axi_burst_addr
  import axi_slv_pkg::*;
#(
  parameter int WIDTH_AD    = 32,
  parameter int WIDTH_DSB   = 2,
  parameter int ADDR_LENGTH = 12
) (
  input  logic [WIDTH_AD-1:0] addr,
  input  logic [2:0]          size,
  input  logic [3:0]          len,
  input  logic [1:0]          burst,
  output logic [WIDTH_AD-1:0] next_addr
);

  logic [2:0]             size_eff;
  logic [ADDR_LENGTH-1:0] lo;
  logic [ADDR_LENGTH-1:0] step;
  logic [ADDR_LENGTH-1:0] wrap_mask;
  logic [ADDR_LENGTH-1:0] incr_lo;
  logic [ADDR_LENGTH-1:0] wrap_lo;
  logic [ADDR_LENGTH-1:0] next_lo;

  always_comb begin
    size_eff  = (size > 3'(WIDTH_DSB)) ? 3'(WIDTH_DSB) : size;
    step      = ADDR_LENGTH'(1) << size_eff;
    lo        = addr[ADDR_LENGTH-1:0];
    // Align before stepping so an unaligned start lands on the next aligned beat.
    incr_lo   = (lo & ~(step - ADDR_LENGTH'(1))) + step;
    wrap_mask = ((ADDR_LENGTH'(len) + ADDR_LENGTH'(1)) << size_eff) - ADDR_LENGTH'(1);
    wrap_lo   = (lo & ~wrap_mask) | ((lo + step) & wrap_mask);
    case (burst)
      BURST_FIXED: next_lo = lo;
      BURST_WRAP:  next_lo = len_wrappable(len) ? wrap_lo : incr_lo;
      default:     next_lo = incr_lo;
    endcase
    next_addr = {addr[WIDTH_AD-1:ADDR_LENGTH], next_lo};
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI3 memory slave: byte-strobed RAM with independent single-outstanding write and read FSMs.
//   state  | meaning
//   W_IDLE | AWREADY high, waiting for a write address
//   W_DATA | WREADY high, accepting beats until AWLEN+1 seen
//   W_RESP | BVALID high with OKAY/SLVERR until BREADY
//   R_IDLE | ARREADY high, waiting for a read address
//   R_DATA | RVALID high, next beat loaded on each RREADY
module axi_mem_slave
  import axi_slv_pkg::*;
#(
  parameter int WIDTH_ID    = 4,
  parameter int WIDTH_AD    = 32,
  parameter int WIDTH_DA    = 32,
  parameter int WIDTH_DS    = WIDTH_DA / 8,
  parameter int WIDTH_DSB   = $clog2(WIDTH_DS),
  parameter int ADDR_LENGTH = 12
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [WIDTH_ID-1:0] AWID,
  input  logic [WIDTH_AD-1:0] AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [1:0]          AWLOCK,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [WIDTH_ID-1:0] WID,
  input  logic [WIDTH_DA-1:0] WDATA,
  input  logic [WIDTH_DS-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [WIDTH_ID-1:0] BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [WIDTH_ID-1:0] ARID,
  input  logic [WIDTH_AD-1:0] ARADDR,
  input  logic [3:0]          ARLEN,
  input  logic [1:0]          ARLOCK,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [WIDTH_ID-1:0] RID,
  output logic [WIDTH_DA-1:0] RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int DEPTH = 2 ** (ADDR_LENGTH - WIDTH_DSB);

  logic [WIDTH_DA-1:0] mem [DEPTH];

  w_state_e w_state, w_state_nxt;
  r_state_e r_state, r_state_nxt;

  logic [WIDTH_ID-1:0] aw_id;
  logic [WIDTH_AD-1:0] aw_addr, aw_addr_nxt;
  logic [3:0]          aw_len;
  logic [2:0]          aw_size;
  logic [1:0]          aw_burst;
  logic [3:0]          w_cnt;
  logic                w_err;

  logic [WIDTH_AD-1:0] ar_addr, r_addr_nxt;
  logic [3:0]          ar_len;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;
  logic [3:0]          r_cnt;

  logic [WIDTH_AD-1:0] rb_addr;
  logic [3:0]          rb_len;
  logic [2:0]          rb_size;
  logic [1:0]          rb_burst;

  logic aw_hs, w_hs, ar_hs, r_hs, w_last_beat, r_last_beat;
  logic unused_lock;

  assign unused_lock = ^{AWLOCK, ARLOCK};

  assign aw_hs       = AWVALID && AWREADY;
  assign w_hs        = WVALID && WREADY;
  assign ar_hs       = ARVALID && ARREADY;
  assign r_hs        = RVALID && RREADY;
  assign w_last_beat = (w_cnt == aw_len);
  assign r_last_beat = (r_cnt == ar_len);

  // ---------------- write channel ----------------
  always_ff @(posedge ACLK) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_state_nxt = W_RESP;
      W_RESP:  if (BREADY) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    BRESP   = RESP_OKAY;
    BID     = '0;
    if (!ARESET) begin
      case (w_state)
        W_IDLE: AWREADY = 1'b1;
        W_DATA: WREADY  = 1'b1;
        W_RESP: begin
          BVALID = 1'b1;
          BRESP  = w_err ? RESP_SLVERR : RESP_OKAY;
          BID    = aw_id;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_id    <= '0;
      aw_addr  <= '0;
      aw_len   <= '0;
      aw_size  <= '0;
      aw_burst <= '0;
      w_cnt    <= '0;
      w_err    <= 1'b0;
    end else if (aw_hs) begin
      aw_id    <= AWID;
      aw_addr  <= AWADDR;
      aw_len   <= AWLEN;
      aw_size  <= AWSIZE;
      aw_burst <= AWBURST;
      w_cnt    <= '0;
      w_err    <= 1'b0;
    end else if (w_hs) begin
      aw_addr <= aw_addr_nxt;
      w_cnt   <= w_cnt + 4'd1;
      if ((WID != aw_id) || (WLAST != w_last_beat)) w_err <= 1'b1;
    end
  end

  // Memory is deliberately outside reset so contents survive an ARESET pulse.
  always_ff @(posedge ACLK) begin
    if (w_hs) begin
      for (int i = 0; i < WIDTH_DS; i++) begin
        if (WSTRB[i]) mem[aw_addr[ADDR_LENGTH-1:WIDTH_DSB]][8*i +: 8] <= WDATA[8*i +: 8];
      end
    end
  end

  axi_burst_addr #(
    .WIDTH_AD    (WIDTH_AD),
    .WIDTH_DSB   (WIDTH_DSB),
    .ADDR_LENGTH (ADDR_LENGTH)
  ) u_w_addr (
    .addr      (aw_addr),
    .size      (aw_size),
    .len       (aw_len),
    .burst     (aw_burst),
    .next_addr (aw_addr_nxt)
  );

  // ---------------- read channel ----------------
  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs && r_last_beat) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    RRESP   = RESP_OKAY;
    if (!ARESET) begin
      ARREADY = (r_state == R_IDLE);
      RVALID  = (r_state == R_DATA);
    end
  end

  // In R_IDLE the stepper works on the incoming AR so beat 1's address is ready at handshake.
  assign rb_addr  = (r_state == R_IDLE) ? ARADDR  : ar_addr;
  assign rb_len   = (r_state == R_IDLE) ? ARLEN   : ar_len;
  assign rb_size  = (r_state == R_IDLE) ? ARSIZE  : ar_size;
  assign rb_burst = (r_state == R_IDLE) ? ARBURST : ar_burst;

  axi_burst_addr #(
    .WIDTH_AD    (WIDTH_AD),
    .WIDTH_DSB   (WIDTH_DSB),
    .ADDR_LENGTH (ADDR_LENGTH)
  ) u_r_addr (
    .addr      (rb_addr),
    .size      (rb_size),
    .len       (rb_len),
    .burst     (rb_burst),
    .next_addr (r_addr_nxt)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      RID      <= '0;
      RDATA    <= '0;
      RLAST    <= 1'b0;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      ar_burst <= '0;
      r_cnt    <= '0;
    end else if (ar_hs) begin
      RID      <= ARID;
      RDATA    <= mem[ARADDR[ADDR_LENGTH-1:WIDTH_DSB]];
      RLAST    <= (ARLEN == 4'd0);
      ar_addr  <= r_addr_nxt;
      ar_len   <= ARLEN;
      ar_size  <= ARSIZE;
      ar_burst <= ARBURST;
      r_cnt    <= '0;
    end else if (r_hs && !r_last_beat) begin
      RDATA   <= mem[ar_addr[ADDR_LENGTH-1:WIDTH_DSB]];
      RLAST   <= ((r_cnt + 4'd1) == ar_len);
      ar_addr <= r_addr_nxt;
      r_cnt   <= r_cnt + 4'd1;
    end else if (r_hs) begin
      RLAST <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: burst types, strobes, error response, stalls, reset abort.
module tb_axi_mem_slave;

  localparam int LIM = 40;

  logic        ACLK, ARESET;
  logic [3:0]  AWID, WID, BID, ARID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]  AWLEN, ARLEN, WSTRB;
  logic [1:0]  AWLOCK, ARLOCK, AWBURST, ARBURST, BRESP, RRESP;
  logic [2:0]  AWSIZE, ARSIZE;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  axi_mem_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWLOCK(AWLOCK), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARLOCK(ARLOCK), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];
  logic [31:0] rdat [16];
  logic        rlast_q [16];
  logic [1:0]  b_resp;
  logic [3:0]  b_id;
  int          b_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input int last_at,
                           input int bad_wid_at, input int bready_dly);
    int cyc;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWLOCK = 2'b01;
    AWVALID = 1'b1;
    cyc = 0;
    while (!AWREADY && cyc < LIM) begin tick(); cyc++; end
    chk("awready", 32'(AWREADY), 32'd1);
    tick();
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      WID = (i == bad_wid_at) ? ~id : id;
      WDATA = wdat[i]; WSTRB = wstb[i]; WLAST = (i == last_at); WVALID = 1'b1;
      cyc = 0;
      while (!WREADY && cyc < LIM) begin tick(); cyc++; end
      chk("wready", 32'(WREADY), 32'd1);
      tick();
    end
    WVALID = 1'b0; WLAST = 1'b0;
    cyc = 0;
    while (!BVALID && cyc < LIM) begin tick(); cyc++; end
    chk("bvalid", 32'(BVALID), 32'd1);
    b_hold = 0;
    for (int i = 0; i < bready_dly; i++) begin
      if (BVALID) b_hold++;
      tick();
    end
    BREADY = 1'b1; b_resp = BRESP; b_id = BID;
    tick();
    BREADY = 1'b0;
    chk("bvalid_drop", 32'(BVALID), 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input logic toggle);
    int cyc, beats;
    logic stalled;
    logic [31:0] hold;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARLOCK = 2'b10;
    ARVALID = 1'b1;
    cyc = 0;
    while (!ARREADY && cyc < LIM) begin tick(); cyc++; end
    chk("arready", 32'(ARREADY), 32'd1);
    tick();
    ARVALID = 1'b0;
    chk("rvalid_first", 32'(RVALID), 32'd1);
    beats = 0; cyc = 0; stalled = 1'b0; hold = '0;
    while (beats <= int'(len) && cyc < LIM) begin
      RREADY = toggle ? (cyc % 2 == 1) : 1'b1;
      if (stalled && RVALID) chk("rdata_stable", RDATA, hold);
      if (RVALID && RREADY) begin
        rdat[beats] = RDATA; rlast_q[beats] = RLAST;
        chk("rid", 32'(RID), 32'(id));
        chk("rresp", 32'(RRESP), 32'd0);
        beats++; stalled = 1'b0;
      end else if (RVALID) begin
        stalled = 1'b1; hold = RDATA;
      end
      tick();
      cyc++;
    end
    RREADY = 1'b0;
    chk("r_beats", 32'(beats), 32'(len) + 32'd1);
    chk("arready_after", 32'(ARREADY), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    ARESET = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWLOCK = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARLOCK = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    RREADY = 1'b0;
    for (int i = 0; i < 16; i++) begin wdat[i] = '0; wstb[i] = 4'hF; end
    repeat (3) tick();
    chk("rst_awready", 32'(AWREADY), 32'd0);
    chk("rst_wready", 32'(WREADY), 32'd0);
    chk("rst_bvalid", 32'(BVALID), 32'd0);
    chk("rst_bid", 32'(BID), 32'd0);
    chk("rst_arready", 32'(ARREADY), 32'd0);
    chk("rst_rvalid", 32'(RVALID), 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_rlast", 32'(RLAST), 32'd0);
    ARESET = 1'b0;
    tick();
    chk("post_rst_awready", 32'(AWREADY), 32'd1);
    chk("post_rst_arready", 32'(ARREADY), 32'd1);

    // single beat write / read back
    wdat[0] = 32'hDEADBEEF;
    axi_write(32'h4, 4'd0, 3'd2, 2'b01, 4'h3, 0, -1, 0);
    chk("t1_bresp", 32'(b_resp), 32'd0);
    chk("t1_bid", 32'(b_id), 32'h3);
    axi_read(32'h4, 4'd0, 3'd2, 2'b01, 4'h5, 1'b0);
    chk("t1_rdata", rdat[0], 32'hDEADBEEF);
    chk("t1_rlast", 32'(rlast_q[0]), 32'd1);

    // INCR x4, read back with RREADY toggling
    for (int i = 0; i < 4; i++) wdat[i] = 32'(i + 1);
    axi_write(32'h10, 4'd3, 3'd2, 2'b01, 4'h1, 3, -1, 0);
    chk("t2_bresp", 32'(b_resp), 32'd0);
    axi_read(32'h10, 4'd3, 3'd2, 2'b01, 4'h2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_rdata", rdat[i], 32'(i + 1));
      chk("t2_rlast", 32'(rlast_q[i]), 32'(i == 3));
    end

    // WRAP x4 from 0x38 -> 0x38,0x3C,0x30,0x34
    for (int i = 0; i < 4; i++) wdat[i] = 32'hA0 + 32'(i);
    axi_write(32'h38, 4'd3, 3'd2, 2'b10, 4'h4, 3, -1, 0);
    axi_read(32'h30, 4'd3, 3'd2, 2'b01, 4'h4, 1'b0);
    chk("t3_w30", rdat[0], 32'hA2);
    chk("t3_w34", rdat[1], 32'hA3);
    chk("t3_w38", rdat[2], 32'hA0);
    chk("t3_w3c", rdat[3], 32'hA1);

    // narrow byte write on lane 1
    wdat[0] = 32'h11223344;
    axi_write(32'h0, 4'd0, 3'd2, 2'b01, 4'h0, 0, -1, 0);
    wdat[0] = 32'h0000AA00; wstb[0] = 4'b0010;
    axi_write(32'h1, 4'd0, 3'd0, 2'b01, 4'h0, 0, -1, 0);
    wstb[0] = 4'hF;
    axi_read(32'h0, 4'd0, 3'd0, 2'b01, 4'h0, 1'b0);
    chk("t4_byte", rdat[0], 32'h1122AA44);

    // FIXED burst keeps hitting one word
    wdat[0] = 32'h11111111; wdat[1] = 32'h22222222;
    axi_write(32'h40, 4'd1, 3'd2, 2'b00, 4'h2, 1, -1, 0);
    axi_read(32'h44, 4'd0, 3'd2, 2'b01, 4'h2, 1'b0);
    chk("t5_next_untouched", rdat[0], 32'h0);
    axi_read(32'h40, 4'd1, 3'd2, 2'b00, 4'h2, 1'b0);
    chk("t5_fixed0", rdat[0], 32'h22222222);
    chk("t5_fixed1", rdat[1], 32'h22222222);

    // early WLAST -> SLVERR, BVALID held while BREADY low
    for (int i = 0; i < 4; i++) wdat[i] = 32'hC0 + 32'(i);
    axi_write(32'h100, 4'd3, 3'd2, 2'b01, 4'h6, 1, -1, 5);
    chk("t6_bresp", 32'(b_resp), 32'd2);
    chk("t6_bhold", 32'(b_hold), 32'd5);
    chk("t6_bid", 32'(b_id), 32'h6);
    axi_write(32'h100, 4'd3, 3'd2, 2'b01, 4'h6, 3, 2, 0);
    chk("t6_wid_err", 32'(b_resp), 32'd2);
    axi_read(32'h100, 4'd3, 3'd2, 2'b01, 4'h6, 1'b0);
    chk("t6_data3", rdat[3], 32'hC3);

    // aliasing above ADDR_LENGTH and INCR wrap at top of memory
    axi_read(32'h1004, 4'd0, 3'd2, 2'b01, 4'h1, 1'b0);
    chk("t7_alias", rdat[0], 32'hDEADBEEF);
    wdat[0] = 32'h77; wdat[1] = 32'h88;
    axi_write(32'hFFC, 4'd1, 3'd2, 2'b01, 4'h7, 1, -1, 0);
    chk("t7_bresp_ok", 32'(b_resp), 32'd0);
    axi_read(32'hFFC, 4'd1, 3'd2, 2'b01, 4'h7, 1'b0);
    chk("t7_top", rdat[0], 32'h77);
    chk("t7_wrap0", rdat[1], 32'h88);

    // concurrent channels, and read load coinciding with a write beat to the same word
    for (int i = 0; i < 4; i++) wdat[i] = 32'h31 + 32'(i);
    fork
      axi_write(32'h300, 4'd3, 3'd2, 2'b01, 4'h8, 3, -1, 0);
      axi_read(32'h10, 4'd3, 3'd2, 2'b01, 4'h9, 1'b0);
    join
    chk("t8_bresp", 32'(b_resp), 32'd0);
    for (int i = 0; i < 4; i++) chk("t8_rdata", rdat[i], 32'(i + 1));
    wdat[0] = 32'h12345678;
    fork
      axi_write(32'h4, 4'd0, 3'd2, 2'b01, 4'h1, 0, -1, 0);
      begin
        tick();
        axi_read(32'h4, 4'd0, 3'd2, 2'b01, 4'h1, 1'b0);
      end
    join
    chk("t8_prewrite", rdat[0], 32'hDEADBEEF);
    axi_read(32'h4, 4'd0, 3'd2, 2'b01, 4'h1, 1'b0);
    chk("t8_postwrite", rdat[0], 32'h12345678);

    // reset during beat 2 of a 4-beat read
    for (int i = 0; i < 4; i++) wdat[i] = 32'h5 + 32'(i);
    axi_write(32'h200, 4'd3, 3'd2, 2'b01, 4'hA, 3, -1, 0);
    ARID = 4'h7; ARADDR = 32'h200; ARLEN = 4'd3; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
    cyc = 0;
    while (!ARREADY && cyc < LIM) begin tick(); cyc++; end
    chk("t9_arready", 32'(ARREADY), 32'd1);
    tick();
    ARVALID = 1'b0;
    chk("t9_beat1", RDATA, 32'h5);
    RREADY = 1'b1;
    tick();
    chk("t9_beat2", RDATA, 32'h6);
    chk("t9_beat2_valid", 32'(RVALID), 32'd1);
    ARESET = 1'b1; RREADY = 1'b0;
    tick();
    chk("t9_rvalid_rst", 32'(RVALID), 32'd0);
    chk("t9_arready_rst", 32'(ARREADY), 32'd0);
    chk("t9_rdata_rst", RDATA, 32'd0);
    ARESET = 1'b0;
    tick();
    chk("t9_arready_rel", 32'(ARREADY), 32'd1);
    chk("t9_rvalid_rel", 32'(RVALID), 32'd0);
    axi_read(32'h200, 4'd3, 3'd2, 2'b01, 4'hB, 1'b0);
    for (int i = 0; i < 4; i++) chk("t9_mem", rdat[i], 32'h5 + 32'(i));
    axi_read(32'h4, 4'd0, 3'd2, 2'b01, 4'hB, 1'b0);
    chk("t9_mem_old", rdat[0], 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
